// File: rtl/single_cycle_cpu_top.sv
// ---------------------------------------------------------------------------
// single_cycle_cpu_top
//   Single-cycle 32-bit MIPS-subset processor. One instruction retires on
//   every rising clock edge. Program, data and initial register contents are
//   preloaded hierarchically through _IM.instMemory, _DM.dataMem and
//   _RP.register; results are observed the same way.
//
// Ports
//   clk : sole clock, all state changes on the rising edge
//   rst : asynchronous active-low reset, forces the PC to 0 and blocks all
//         register and memory writes while low
// ---------------------------------------------------------------------------

// Instruction memory: combinational word read, contents preloaded externally.
module cpu_imem #(
   parameter int WORDS = 256,
   parameter int AW    = 8
) (
   input  logic [AW-1:0] addr,
   output logic [31:0]   rdata
);
   reg [31:0] instMemory [0:WORDS-1];

   assign rdata = instMemory[addr];
endmodule

// Data memory: combinational read, write on the rising edge.
module cpu_dmem #(
   parameter int WORDS = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   reg [31:0] dataMem [0:WORDS-1];

   assign rdata = dataMem[addr];

   // Store port; memory contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         dataMem[addr] <= wdata;
      end
   end
endmodule

// Register file: two combinational read ports, one write port, $0 hardwired.
module cpu_regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   reg [31:0] register [0:31];

   assign rd1 = (ra1 == 5'd0) ? 32'h0000_0000 : register[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'h0000_0000 : register[ra2];

   // Writeback; writes aimed at $0 are dropped so it always reads zero.
   always_ff @(posedge clk) begin
      if (we && (wa != 5'd0)) begin
         register[wa] <= wd;
      end
   end
endmodule

module single_cycle_cpu_top #(
   parameter int IM_WORDS = 256,
   parameter int DM_WORDS = 256
) (
   input  logic clk,
   input  logic rst
);
   localparam int IM_AW = $clog2(IM_WORDS);
   localparam int DM_AW = $clog2(DM_WORDS);

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   logic [31:0] pc_r;
   logic [31:0] pc_next_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] instr_s;
   logic [5:0]  op_s;
   logic [5:0]  funct_s;
   logic [4:0]  rs_s;
   logic [4:0]  rt_s;
   logic [4:0]  rd_s;
   logic [4:0]  shamt_s;
   logic [15:0] imm_s;
   logic [31:0] imm_sext_s;
   logic [31:0] rs_val_s;
   logic [31:0] rt_val_s;
   logic [31:0] mem_addr_s;
   logic [31:0] dm_rdata_s;
   logic        rf_we_s;
   logic [4:0]  rf_wa_s;
   logic [31:0] rf_wd_s;
   logic        dm_we_s;
   logic        unused_bits_s;

   assign op_s       = instr_s[31:26];
   assign rs_s       = instr_s[25:21];
   assign rt_s       = instr_s[20:16];
   assign rd_s       = instr_s[15:11];
   assign shamt_s    = instr_s[10:6];
   assign funct_s    = instr_s[5:0];
   assign imm_s      = instr_s[15:0];
   assign imm_sext_s = sext16(imm_s);
   assign pc_plus4_s = pc_r + 32'd4;
   assign mem_addr_s = rs_val_s + imm_sext_s;

   // Byte-offset bits and address bits above the memory size are ignored.
   assign unused_bits_s = ^{pc_r[1:0], mem_addr_s[1:0], mem_addr_s[31:DM_AW+2]};

   cpu_imem #(.WORDS(IM_WORDS), .AW(IM_AW)) _IM (
      .addr  (pc_r[IM_AW+1:2]),
      .rdata (instr_s)
   );

   // Writes are gated by rst so nothing changes while reset is held.
   cpu_regfile _RP (
      .clk (clk),
      .we  (rf_we_s & rst),
      .ra1 (rs_s),
      .ra2 (rt_s),
      .wa  (rf_wa_s),
      .wd  (rf_wd_s),
      .rd1 (rs_val_s),
      .rd2 (rt_val_s)
   );

   cpu_dmem #(.WORDS(DM_WORDS), .AW(DM_AW)) _DM (
      .clk   (clk),
      .we    (dm_we_s & rst),
      .addr  (mem_addr_s[DM_AW+1:2]),
      .wdata (rt_val_s),
      .rdata (dm_rdata_s)
   );

   // Decode, ALU, writeback select and next-PC selection.
   always_comb begin
      rf_we_s   = 1'b0;
      rf_wa_s   = rt_s;
      rf_wd_s   = 32'h0000_0000;
      dm_we_s   = 1'b0;
      pc_next_s = pc_plus4_s;
      case (op_s)
         6'h00: begin
            rf_wa_s = rd_s;
            rf_we_s = 1'b1;
            case (funct_s)
               6'h20:   rf_wd_s = rs_val_s + rt_val_s;
               6'h22:   rf_wd_s = rs_val_s - rt_val_s;
               6'h24:   rf_wd_s = rs_val_s & rt_val_s;
               6'h25:   rf_wd_s = rs_val_s | rt_val_s;
               6'h2A:   rf_wd_s = {31'd0, ($signed(rs_val_s) < $signed(rt_val_s))};
               6'h00:   rf_wd_s = rt_val_s << shamt_s;
               default: rf_we_s = 1'b0;
            endcase
         end
         6'h08: begin
            rf_we_s = 1'b1;
            rf_wd_s = rs_val_s + imm_sext_s;
         end
         6'h0C: begin
            rf_we_s = 1'b1;
            rf_wd_s = rs_val_s & {16'h0000, imm_s};
         end
         6'h0D: begin
            rf_we_s = 1'b1;
            rf_wd_s = rs_val_s | {16'h0000, imm_s};
         end
         6'h0F: begin
            rf_we_s = 1'b1;
            rf_wd_s = {imm_s, 16'h0000};
         end
         6'h0A: begin
            rf_we_s = 1'b1;
            rf_wd_s = {31'd0, ($signed(rs_val_s) < $signed(imm_sext_s))};
         end
         6'h23: begin
            rf_we_s = 1'b1;
            rf_wd_s = dm_rdata_s;
         end
         6'h2B: begin
            dm_we_s = 1'b1;
         end
         6'h04: begin
            if (rs_val_s == rt_val_s) begin
               pc_next_s = pc_plus4_s + {imm_sext_s[29:0], 2'b00};
            end else begin
               pc_next_s = pc_plus4_s;
            end
         end
         6'h05: begin
            if (rs_val_s != rt_val_s) begin
               pc_next_s = pc_plus4_s + {imm_sext_s[29:0], 2'b00};
            end else begin
               pc_next_s = pc_plus4_s;
            end
         end
         6'h02: begin
            pc_next_s = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
         end
         6'h03: begin
            pc_next_s = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
            rf_we_s   = 1'b1;
            rf_wa_s   = 5'd31;
            rf_wd_s   = pc_plus4_s;
         end
         default: begin
            rf_we_s = 1'b0;
         end
      endcase
   end

   // Program counter; the only state touched by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r <= 32'h0000_0000;
      end else begin
         pc_r <= pc_next_s;
      end
   end
endmodule

// File: tb/tb_single_cycle_cpu_top.sv
module tb_single_cycle_cpu_top;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [31:0] m_reg [0:31];
   logic [31:0] m_dm  [0:255];
   logic [31:0] m_im  [0:255];
   logic [31:0] m_pc;

   single_cycle_cpu_top #(.IM_WORDS(256), .DM_WORDS(256)) dut (
      .clk (clk),
      .rst (rst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
      return {op, tgt};
   endfunction

   task automatic clear_all();
      for (int i = 0; i < 256; i++) begin
         dut._IM.instMemory[i] = 32'h0;
         dut._DM.dataMem[i]    = 32'h0;
      end
      for (int i = 0; i < 32; i++) dut._RP.register[i] = 32'h0;
   endtask

   task automatic hold_reset();
      rst = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Instruction-set reference model: executes one instruction of m_im.
   task automatic model_step();
      logic [31:0] ins, a, b, se, nxt, addr;
      logic [4:0]  rs, rt, rd;
      ins = m_im[m_pc[9:2]];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      a  = m_reg[rs];  b  = m_reg[rt];
      se = {{16{ins[15]}}, ins[15:0]};
      nxt  = m_pc + 32'd4;
      addr = a + se;
      case (ins[31:26])
         6'h00: case (ins[5:0])
            6'h20: if (rd != 5'd0) m_reg[rd] = a + b;
            6'h22: if (rd != 5'd0) m_reg[rd] = a - b;
            6'h24: if (rd != 5'd0) m_reg[rd] = a & b;
            6'h25: if (rd != 5'd0) m_reg[rd] = a | b;
            6'h2A: if (rd != 5'd0) m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00: if (rd != 5'd0) m_reg[rd] = b << ins[10:6];
            default: ;
         endcase
         6'h08: if (rt != 5'd0) m_reg[rt] = a + se;
         6'h0C: if (rt != 5'd0) m_reg[rt] = a & {16'h0, ins[15:0]};
         6'h0D: if (rt != 5'd0) m_reg[rt] = a | {16'h0, ins[15:0]};
         6'h0F: if (rt != 5'd0) m_reg[rt] = {ins[15:0], 16'h0};
         6'h0A: if (rt != 5'd0) m_reg[rt] = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
         6'h23: if (rt != 5'd0) m_reg[rt] = m_dm[addr[9:2]];
         6'h2B: m_dm[addr[9:2]] = b;
         6'h04: if (a == b) nxt = nxt + se * 32'd4;
         6'h05: if (a != b) nxt = nxt + se * 32'd4;
         6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
         6'h03: begin
            m_reg[31] = nxt;
            nxt = {nxt[31:28], ins[25:0], 2'b00};
         end
         default: ;
      endcase
      m_pc = nxt;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      int k;
      rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31)); sh = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      k = $urandom_range(0, 18);
      case (k)
         0:  return enc_r(rs, rt, rd, sh, 6'h20);
         1:  return enc_r(rs, rt, rd, sh, 6'h22);
         2:  return enc_r(rs, rt, rd, sh, 6'h24);
         3:  return enc_r(rs, rt, rd, sh, 6'h25);
         4:  return enc_r(rs, rt, rd, sh, 6'h2A);
         5:  return enc_r(rs, rt, rd, sh, 6'h00);
         6:  return enc_i(6'h08, rs, rt, imm);
         7:  return enc_i(6'h0C, rs, rt, imm);
         8:  return enc_i(6'h0D, rs, rt, imm);
         9:  return enc_i(6'h0F, rs, rt, imm);
         10: return enc_i(6'h0A, rs, rt, imm);
         11: return enc_i(6'h23, rs, rt, imm);
         12: return enc_i(6'h2B, rs, rt, imm);
         13: return enc_i(6'h04, rs, ($urandom_range(0, 1) == 0) ? rs : rt, imm);
         14: return enc_i(6'h05, rs, ($urandom_range(0, 1) == 0) ? rs : rt, imm);
         15: return enc_j(6'h02, 26'($urandom));
         16: return enc_j(6'h03, 26'($urandom));
         17: return enc_i(($urandom_range(0, 1) == 0) ? 6'h3F : 6'h10, rs, rt, imm);
         default: return enc_r(rs, rt, rd, sh, 6'h21);
      endcase
   endfunction

   task automatic test_reset();
      clear_all();
      #19;
      n_tests++;
      if (dut.pc_r !== 32'h0) begin
         n_fail++; $display("FAIL reset_pc got=%h exp=%h", dut.pc_r, 32'h0);
      end
      release_reset();
      run(1);
      n_tests++;
      if (dut.pc_r !== 32'h4) begin
         n_fail++; $display("FAIL fetch_pc1 got=%h exp=%h", dut.pc_r, 32'h4);
      end
      run(1);
      n_tests++;
      if (dut.pc_r !== 32'h8) begin
         n_fail++; $display("FAIL fetch_pc2 got=%h exp=%h", dut.pc_r, 32'h8);
      end
   endtask

   task automatic test_alu();
      logic [31:0] exp [0:4];
      hold_reset();
      clear_all();
      dut._IM.instMemory[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      dut._IM.instMemory[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
      dut._IM.instMemory[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      dut._IM.instMemory[3] = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);
      dut._IM.instMemory[4] = enc_r(5'd2, 5'd1, 5'd5, 5'd0, 6'h2A);
      dut._IM.instMemory[5] = enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h24);
      dut._IM.instMemory[6] = enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h25);
      exp[0] = 32'd2; exp[1] = 32'd8; exp[2] = 32'd1; exp[3] = 32'd5; exp[4] = 32'hFFFF_FFFD;
      release_reset();
      run(7);
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (dut._RP.register[i+3] !== exp[i]) begin
            n_fail++;
            $display("FAIL alu_r%0d got=%h exp=%h", i + 3, dut._RP.register[i+3], exp[i]);
         end
      end
   endtask

   task automatic test_memory();
      hold_reset();
      clear_all();
      dut._DM.dataMem[1] = 32'h1234_5678;
      dut._IM.instMemory[0] = enc_i(6'h23, 5'd0, 5'd8, 16'd4);
      dut._IM.instMemory[1] = enc_i(6'h2B, 5'd0, 5'd8, 16'd8);
      dut._IM.instMemory[2] = enc_i(6'h23, 5'd0, 5'd9, 16'd8);
      release_reset();
      run(3);
      n_tests++;
      if (dut._RP.register[8] !== 32'h1234_5678) begin
         n_fail++; $display("FAIL mem_r8 got=%h exp=%h", dut._RP.register[8], 32'h1234_5678);
      end
      n_tests++;
      if (dut._RP.register[9] !== 32'h1234_5678) begin
         n_fail++; $display("FAIL mem_r9 got=%h exp=%h", dut._RP.register[9], 32'h1234_5678);
      end
      n_tests++;
      if (dut._DM.dataMem[2] !== 32'h1234_5678) begin
         n_fail++; $display("FAIL mem_dm2 got=%h exp=%h", dut._DM.dataMem[2], 32'h1234_5678);
      end
   endtask

   task automatic test_branch();
      hold_reset();
      clear_all();
      dut._IM.instMemory[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
      dut._IM.instMemory[1] = enc_i(6'h08, 5'd0, 5'd10, 16'd1);
      dut._IM.instMemory[2] = enc_i(6'h05, 5'd1, 5'd1, 16'd1);
      dut._IM.instMemory[3] = enc_i(6'h08, 5'd0, 5'd11, 16'd7);
      release_reset();
      run(3);
      n_tests++;
      if (dut._RP.register[10] !== 32'd0) begin
         n_fail++; $display("FAIL br_r10 got=%h exp=%h", dut._RP.register[10], 32'd0);
      end
      n_tests++;
      if (dut._RP.register[11] !== 32'd7) begin
         n_fail++; $display("FAIL br_r11 got=%h exp=%h", dut._RP.register[11], 32'd7);
      end
      n_tests++;
      if (dut.pc_r !== 32'd16) begin
         n_fail++; $display("FAIL br_pc got=%h exp=%h", dut.pc_r, 32'd16);
      end
   endtask

   task automatic test_jal();
      hold_reset();
      clear_all();
      dut._IM.instMemory[0]  = enc_j(6'h03, 26'd16);
      dut._IM.instMemory[16] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
      release_reset();
      run(1);
      n_tests++;
      if (dut.pc_r !== 32'h40) begin
         n_fail++; $display("FAIL jal_pc got=%h exp=%h", dut.pc_r, 32'h40);
      end
      run(1);
      n_tests++;
      if (dut._RP.register[31] !== 32'd4) begin
         n_fail++; $display("FAIL jal_r31 got=%h exp=%h", dut._RP.register[31], 32'd4);
      end
      n_tests++;
      if (dut._RP.register[0] !== 32'd0) begin
         n_fail++; $display("FAIL zero_reg got=%h exp=%h", dut._RP.register[0], 32'd0);
      end
      n_tests++;
      if (dut.pc_r !== 32'h44) begin
         n_fail++; $display("FAIL jal_pc2 got=%h exp=%h", dut.pc_r, 32'h44);
      end
   endtask

   task automatic test_reset_midrun();
      logic [31:0] exp [0:5];
      hold_reset();
      clear_all();
      dut._IM.instMemory[0] = enc_i(6'h08, 5'd12, 5'd12, 16'd1);
      dut._IM.instMemory[1] = enc_i(6'h08, 5'd0, 5'd13, 16'd3);
      dut._IM.instMemory[2] = enc_i(6'h08, 5'd0, 5'd14, 16'd4);
      dut._IM.instMemory[3] = enc_r(5'd13, 5'd14, 5'd15, 5'd0, 6'h20);
      dut._IM.instMemory[4] = enc_r(5'd0, 5'd15, 5'd16, 5'd2, 6'h00);
      dut._IM.instMemory[5] = enc_i(6'h08, 5'd0, 5'd17, 16'd99);
      exp[0] = 32'd1; exp[1] = 32'd3; exp[2] = 32'd4; exp[3] = 32'd7; exp[4] = 32'd28; exp[5] = 32'd0;
      release_reset();
      run(5);
      n_tests++;
      if (dut.pc_r !== 32'd20) begin
         n_fail++; $display("FAIL mid_pc5 got=%h exp=%h", dut.pc_r, 32'd20);
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (dut.pc_r !== 32'd0) begin
         n_fail++; $display("FAIL mid_async_pc got=%h exp=%h", dut.pc_r, 32'd0);
      end
      run(1);
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (dut._RP.register[i+12] !== exp[i]) begin
            n_fail++;
            $display("FAIL mid_r%0d got=%h exp=%h", i + 12, dut._RP.register[i+12], exp[i]);
         end
      end
      release_reset();
      run(1);
      n_tests++;
      if (dut._RP.register[12] !== 32'd2 || dut.pc_r !== 32'd4) begin
         n_fail++;
         $display("FAIL mid_rerun got=r12:%h pc:%h exp=r12:%h pc:%h",
                  dut._RP.register[12], dut.pc_r, 32'd2, 32'd4);
      end
   endtask

   task automatic test_random();
      for (int round = 0; round < 8; round++) begin
         hold_reset();
         for (int i = 0; i < 256; i++) begin
            m_im[i] = rand_instr();
            m_dm[i] = $urandom;
            dut._IM.instMemory[i] = m_im[i];
            dut._DM.dataMem[i]    = m_dm[i];
         end
         for (int i = 0; i < 32; i++) begin
            m_reg[i] = (i == 0) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom);
            dut._RP.register[i] = m_reg[i];
         end
         m_pc = 32'h0;
         release_reset();
         for (int c = 0; c < 60; c++) begin
            model_step();
            run(1);
            n_tests++;
            if (dut.pc_r !== m_pc) begin
               n_fail++;
               $display("FAIL rand_pc round=%0d cyc=%0d got=%h exp=%h", round, c, dut.pc_r, m_pc);
            end
         end
         for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (dut._RP.register[i] !== m_reg[i]) begin
               n_fail++;
               $display("FAIL rand_reg round=%0d r%0d got=%h exp=%h", round, i, dut._RP.register[i], m_reg[i]);
            end
         end
         for (int i = 0; i < 256; i++) begin
            n_tests++;
            if (dut._DM.dataMem[i] !== m_dm[i]) begin
               n_fail++;
               $display("FAIL rand_dm round=%0d w%0d got=%h exp=%h", round, i, dut._DM.dataMem[i], m_dm[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_memory();
      test_branch();
      test_jal();
      test_reset_midrun();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
